// File: rtl/types_pkg.sv
// types_pkg: shared strategy output type, strategy ids, switch FSM states and safe output constant
package types_pkg;
  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } output_signals_t;
  typedef enum logic [1:0] {NOP, XOR, INV} strategy_id_t;
  localparam int N_STRATEGIES = 3;
  typedef enum logic [1:0] {RUN, BLANK, ARM} strategy_sw_state_t;
  localparam output_signals_t OUT_SAFE = '0;
endpackage

// File: rtl/strategy_guard_timer.sv
// strategy_guard_timer: loadable down-counter, o_done while the count sits at 1
module strategy_guard_timer #(
  parameter int GUARD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);
  localparam int CW = $clog2(GUARD_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(GUARD_CYCLES);
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == CW'(1);
endmodule

// File: rtl/strategy_switch.sv
// strategy_switch: registered strategy mux with req/ack switching and blanking guard;
// optional STRATEGY_SWITCH_STATS_EN adds saturating switch/reject counters.
module strategy_switch
  import types_pkg::*;
#(
  parameter int N_STRAT      = N_STRATEGIES,
  parameter int SEL_W        = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int DEFAULT_SEL  = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sel_req,
  input  logic [SEL_W-1:0] sel,
  input  output_signals_t strat_out [N_STRAT],
  output logic [N_STRAT-1:0] strat_en,
  output output_signals_t out,
  output logic [SEL_W-1:0] active_sel,
  output logic            busy,
  output logic            sel_ack,
  output logic            sel_err
`ifdef STRATEGY_SWITCH_STATS_EN
  ,
  output logic [15:0]     switch_cnt,
  output logic [15:0]     reject_cnt
`endif
);
  localparam int IW = N_STRAT > 1 ? $clog2(N_STRAT) : 1;
  strategy_sw_state_t r_state, w_nxt;
  logic [SEL_W-1:0] r_active, r_pend;
  output_signals_t r_out;
  logic r_ack, r_err;
  logic w_done, w_load, w_ack, w_err, w_bad;
  logic [IW-1:0] w_idx;
  logic [N_STRAT-1:0] w_one;
  // full-width compare so out-of-range high bits are rejected, never aliased
  assign w_bad = 32'(sel) >= N_STRAT;
  assign w_idx = r_active[IW-1:0];
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      RUN: if (sel_req) begin
        if (w_bad) w_err = 1'b1;
        else if (sel == r_active) w_ack = 1'b1;
        else begin
          w_nxt  = BLANK;
          w_load = 1'b1;
        end
      end
      BLANK: begin
        w_err = sel_req;
        w_nxt = w_done ? ARM : BLANK;
      end
      ARM: begin
        w_err = sel_req;
        w_ack = 1'b1;
        w_nxt = RUN;
      end
      default: w_nxt = RUN;
    endcase
  end
  always_comb begin
    w_one = '0;
    w_one[w_idx] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state  <= RUN;
      r_active <= SEL_W'(DEFAULT_SEL);
      r_pend   <= '0;
      r_out    <= OUT_SAFE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ack   <= w_ack;
      r_err   <= w_err;
      if (w_load) r_pend <= sel;
      if (w_nxt == ARM) r_active <= r_pend;
      r_out <= (w_nxt == RUN) ? strat_out[w_idx] : OUT_SAFE;
    end
  strategy_guard_timer #(.GUARD_CYCLES(GUARD_CYCLES)) u_guard (
    .clock (clock),
    .reset (reset),
    .i_load(w_load),
    .i_en  (r_state == BLANK),
    .o_done(w_done)
  );
  assign strat_en   = (r_state == BLANK) ? '0 : w_one;
  assign out        = r_out;
  assign active_sel = r_active;
  assign busy       = r_state != RUN;
  assign sel_ack    = r_ack;
  assign sel_err    = r_err;
`ifdef STRATEGY_SWITCH_STATS_EN
  logic [15:0] r_sw, r_rej;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_sw  <= '0;
      r_rej <= '0;
    end else begin
      if (r_state == ARM && r_sw != '1) r_sw <= r_sw + 1'b1;
      if (w_err && r_rej != '1) r_rej <= r_rej + 1'b1;
    end
  assign switch_cnt = r_sw;
  assign reject_cnt = r_rej;
`endif
endmodule

// File: tb/tb_strategy_switch.sv
// tb_strategy_switch: directed self-checking bench for strategy_switch (N=3, G=4, default 0)
module tb_strategy_switch;
  import types_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sel_req = 1'b0;
  logic [7:0] sel = '0;
  output_signals_t strat_out [3];
  logic [2:0] strat_en;
  output_signals_t out;
  logic [7:0] active_sel;
  logic busy, sel_ack, sel_err;
`ifdef STRATEGY_SWITCH_STATS_EN
  logic [15:0] switch_cnt, reject_cnt;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  strategy_switch #(.N_STRAT(3), .SEL_W(8), .GUARD_CYCLES(4), .DEFAULT_SEL(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .sel_req   (sel_req),
    .sel       (sel),
    .strat_out (strat_out),
    .strat_en  (strat_en),
    .out       (out),
    .active_sel(active_sel),
    .busy      (busy),
    .sel_ack   (sel_ack),
    .sel_err   (sel_err)
`ifdef STRATEGY_SWITCH_STATS_EN
    ,
    .switch_cnt(switch_cnt),
    .reject_cnt(reject_cnt)
`endif
  );

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_out: got %h want 00", out); end
    checks++; if (active_sel !== 8'd0) begin errors++; $display("FAIL rst_active: got %0d want 0", active_sel); end
    checks++; if (strat_en !== 3'b001) begin errors++; $display("FAIL rst_en: got %b want 001", strat_en); end
    checks++; if ({busy, sel_ack, sel_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {busy, sel_ack, sel_err}); end
    reset = 1'b1;
    #1;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rel_out0: got %h want 00", out); end
    @(negedge clock);
    checks++; if (out !== 8'hA5) begin errors++; $display("FAIL rel_out1: got %h want a5", out); end
    checks++; if (strat_en !== 3'b001) begin errors++; $display("FAIL rel_en: got %b want 001", strat_en); end
  endtask

  task automatic test_switch();
    logic [7:0] e_out;
    logic [2:0] e_en;
    @(negedge clock);
    sel_req = 1'b1;
    sel = 8'd2;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      sel_req = 1'b0;
      e_out = (k >= 5) ? 8'h5A : 8'h00;
      e_en = (k >= 4) ? 3'b100 : 3'b000;
      checks++; if (out !== e_out) begin errors++; $display("FAIL sw_out[%0d]: got %h want %h", k, out, e_out); end
      checks++; if (strat_en !== e_en) begin errors++; $display("FAIL sw_en[%0d]: got %b want %b", k, strat_en, e_en); end
      checks++; if (busy !== (k < 5)) begin errors++; $display("FAIL sw_busy[%0d]: got %b want %b", k, busy, k < 5); end
      checks++; if (sel_ack !== (k == 5)) begin errors++; $display("FAIL sw_ack[%0d]: got %b want %b", k, sel_ack, k == 5); end
      checks++; if (active_sel !== ((k >= 4) ? 8'd2 : 8'd0)) begin errors++; $display("FAIL sw_active[%0d]: got %0d", k, active_sel); end
    end
  endtask

  task automatic test_same_index();
    @(negedge clock);
    sel_req = 1'b1;
    sel = 8'd2;
    strat_out[2] = output_signals_t'(8'h66);
    @(negedge clock);
    sel_req = 1'b0;
    checks++; if (sel_ack !== 1'b1) begin errors++; $display("FAIL same_ack: got %b want 1", sel_ack); end
    checks++; if (out !== 8'h66) begin errors++; $display("FAIL same_out: got %h want 66", out); end
    checks++; if (strat_en !== 3'b100) begin errors++; $display("FAIL same_en: got %b want 100", strat_en); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy[%0d]: got %b want 0", k, busy); end
      @(negedge clock);
    end
    checks++; if (sel_ack !== 1'b0) begin errors++; $display("FAIL same_ack_end: got %b want 0", sel_ack); end
    checks++; if (out !== 8'h66) begin errors++; $display("FAIL same_out_end: got %h want 66", out); end
  endtask

  task automatic test_reject();
    logic [7:0] bad [3];
    bad[0] = 8'd5;
    bad[1] = 8'h83;
    bad[2] = 8'h80;
    @(negedge clock);
    sel_req = 1'b1;
    sel = bad[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k < 2) sel = bad[k+1];
      else sel_req = 1'b0;
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL rej_err[%0d]: got %b want 1", k, sel_err); end
      checks++; if (active_sel !== 8'd2) begin errors++; $display("FAIL rej_active[%0d]: got %0d want 2", k, active_sel); end
      checks++; if ({busy, sel_ack} !== 2'b00) begin errors++; $display("FAIL rej_flags[%0d]: got %b want 00", k, {busy, sel_ack}); end
    end
    @(negedge clock);
    checks++; if ({busy, sel_err} !== 2'b00) begin errors++; $display("FAIL rej_after: got %b want 00", {busy, sel_err}); end
`ifdef STRATEGY_SWITCH_STATS_EN
    checks++; if (reject_cnt !== 16'd3) begin errors++; $display("FAIL rej_cnt: got %0d want 3", reject_cnt); end
    checks++; if (switch_cnt !== 16'd1) begin errors++; $display("FAIL sw_cnt1: got %0d want 1", switch_cnt); end
`endif
  endtask

  task automatic test_req_during_blank();
    logic [7:0] e_out;
    logic [2:0] e_en;
    @(negedge clock);
    sel_req = 1'b1;
    sel = 8'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      sel_req = (k == 0);
      sel = 8'd0;
      e_out = (k == 5) ? 8'h3C : 8'h00;
      e_en = (k >= 4) ? 3'b010 : 3'b000;
      checks++; if (sel_err !== (k == 1)) begin errors++; $display("FAIL blk_err[%0d]: got %b want %b", k, sel_err, k == 1); end
      checks++; if (out !== e_out) begin errors++; $display("FAIL blk_out[%0d]: got %h want %h", k, out, e_out); end
      checks++; if (strat_en !== e_en) begin errors++; $display("FAIL blk_en[%0d]: got %b want %b", k, strat_en, e_en); end
      checks++; if (sel_ack !== (k == 5)) begin errors++; $display("FAIL blk_ack[%0d]: got %b want %b", k, sel_ack, k == 5); end
    end
    checks++; if (active_sel !== 8'd1) begin errors++; $display("FAIL blk_active: got %0d want 1", active_sel); end
`ifdef STRATEGY_SWITCH_STATS_EN
    checks++; if (switch_cnt !== 16'd2) begin errors++; $display("FAIL sw_cnt2: got %0d want 2", switch_cnt); end
    checks++; if (reject_cnt !== 16'd4) begin errors++; $display("FAIL rej_cnt2: got %0d want 4", reject_cnt); end
`endif
  endtask

  task automatic test_reset_mid_switch();
    @(negedge clock);
    sel_req = 1'b1;
    sel = 8'd2;
    @(negedge clock);
    sel_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (active_sel !== 8'd0) begin errors++; $display("FAIL mid_active: got %0d want 0", active_sel); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL mid_out: got %h want 00", out); end
    checks++; if ({busy, sel_ack} !== 2'b00) begin errors++; $display("FAIL mid_flags: got %b want 00", {busy, sel_ack}); end
    checks++; if (strat_en !== 3'b001) begin errors++; $display("FAIL mid_en: got %b want 001", strat_en); end
`ifdef STRATEGY_SWITCH_STATS_EN
    checks++; if ({switch_cnt, reject_cnt} !== 32'd0) begin errors++; $display("FAIL mid_cnts: got %h want 0", {switch_cnt, reject_cnt}); end
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++; if ({busy, sel_ack} !== 2'b00) begin errors++; $display("FAIL post_flags[%0d]: got %b want 00", k, {busy, sel_ack}); end
    end
    checks++; if (active_sel !== 8'd0) begin errors++; $display("FAIL post_active: got %0d want 0", active_sel); end
    checks++; if (out !== 8'hA5) begin errors++; $display("FAIL post_out: got %h want a5", out); end
  endtask

  initial begin
    strat_out[0] = output_signals_t'(8'hA5);
    strat_out[1] = output_signals_t'(8'h3C);
    strat_out[2] = output_signals_t'(8'h5A);
    test_reset();
    test_switch();
    test_same_index();
    test_reject();
    test_req_during_blank();
    test_reset_mid_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/strategy_switch.md
# strategy_switch

Parametrised, registered successor to the combinational strategy selector. Takes the outputs of `N_STRAT` strategy instances, drives exactly one onto `out`, and changes strategy only through a request/acknowledge handshake with a programmable blanking interval, so consumers never see a mixed or stale result. Sits between the strategy instances and the synchronisation output stage; gates each strategy through a per-strategy enable.

## Interface
- `N_STRAT`, 3: number of strategy inputs (≥1).
- `SEL_W`, 8: width of the selection code.
- `GUARD_CYCLES`, 4: blanking cycles on a real switch (≥1).
- `DEFAULT_SEL`, 0: strategy active after reset (< `N_STRAT`).
---
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sel_req`  in  1  one-cycle request to change strategy.
- `sel`  in  SEL_W  requested strategy index; sampled with `sel_req`.
- `strat_out`  in  N_STRAT × output_signals_t  outputs of each strategy.
- `strat_en`  out  N_STRAT  one-hot enable of the active strategy; all zero while blanking.
- `out`  out  output_signals_t  registered selected output.
- `active_sel`  out  SEL_W  index currently driving `out`.
- `busy`  out  1  switch in progress.
- `sel_ack`  out  1  one-cycle pulse: request completed.
- `sel_err`  out  1  one-cycle pulse: request rejected.

## Operation
- States: RUN, BLANK, ARM.
- RUN: `out` ← `strat_out[active_sel]` every edge; `strat_en` = onehot(`active_sel`); `busy`=0.
- `sel_req` in RUN:
  - `sel` ≥ `N_STRAT` → `sel_err` pulse, stay RUN, nothing else changes.
  - `sel` == `active_sel` → `sel_ack` pulse, stay RUN, no blanking.
  - otherwise → latch `sel` as pending; go BLANK, load guard counter with `GUARD_CYCLES`.
- BLANK: `strat_en`=0, `out`=`OUT_SAFE`, `busy`=1; counter decrements each cycle; on reaching 1 → ARM.
- ARM (one cycle): `active_sel` ← pending, `strat_en` = onehot(pending), `out`=`OUT_SAFE`, `busy`=1; → RUN.
- Entering RUN from ARM: `out` ← `strat_out[new]`, `sel_ack` pulse.
- `sel_req` during BLANK/ARM: `sel_err` pulse, request discarded, switch continues unaffected.
- Unused `sel` high bits are compared, not truncated (index 0x83 with `N_STRAT`=3 is an error).

## Timing
- Reset (async assert): state RUN, `active_sel`=`DEFAULT_SEL`, `strat_en`=onehot(`DEFAULT_SEL`), `out`=`OUT_SAFE`, `busy`/`sel_ack`/`sel_err`=0. First edge after release loads `strat_out[DEFAULT_SEL]`.
- Reset mid-switch aborts it; pending request lost, no `sel_ack`.
- Real switch, request sampled at edge E0: after E0..E(G-1) BLANK (G=`GUARD_CYCLES` cycles of `OUT_SAFE`, `strat_en`=0); after E(G) ARM; after E(G+1) RUN with new output and `sel_ack`=1 for that cycle. `out` shows `OUT_SAFE` for exactly G+1 cycles.
- Same-index ack and `sel_err`: visible the cycle after the sampling edge.
- `out` has one cycle of latency from `strat_out` in RUN.

## Configuration
- `STRATEGY_SWITCH_STATS_EN` defined: adds outputs `switch_cnt` (16) and `reject_cnt` (16), reset to 0; `switch_cnt` increments on each ack following a real switch (not same-index acks); `reject_cnt` increments on each `sel_err`; both saturate at 0xFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- In `types_pkg`: `strategy_id_t` enum (NOP, XOR, INV) with `N_STRATEGIES` constant replacing the local enum; `strategy_sw_state_t` (RUN, BLANK, ARM); `OUT_SAFE` constant of type output_signals_t (all zero).
- One sub-module: `strategy_guard_timer` — loadable down-counter asserting `done` on reaching 1.

## Test plan
- Reset release, `strat_out[0]`=0xA5 pattern → `out`=`OUT_SAFE` first cycle, then 0xA5; `strat_en`=3'b001.
- `sel_req`, `sel`=2, G=4 → 5 cycles `OUT_SAFE`, `strat_en`=0 for 4 then 3'b100, `sel_ack` with `out`=`strat_out[2]`, `active_sel`=2.
- `sel_req`, `sel`=`active_sel` → `sel_ack` next cycle, `out` uninterrupted, `busy` never high.
- `sel_req`, `sel`=5 and `sel`=0x83 → `sel_err` each, `active_sel` unchanged; with stats, `reject_cnt`=2.
- `sel_req` during BLANK → `sel_err`, original switch completes on schedule to first target.
- `reset` low in BLANK cycle 2 → immediately `active_sel`=`DEFAULT_SEL`, `out`=`OUT_SAFE`, `busy`=0, no `sel_ack`.
